// File: rtl/out_uart_tx_if.sv
// out_uart_tx_if: bus-side load port plus serial and status outputs of the output UART
interface out_uart_tx_if;
  logic       load;
  logic [7:0] bus;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [7:0] out;
  modport master (output load, bus, input tx, busy, full, overflow, out);
  modport slave (input load, bus, output tx, busy, full, overflow, out);
endinterface

// File: rtl/out_uart_tx.sv
// out_uart_tx: captures bus bytes on load into a FIFO and sends them as 8N1 UART frames
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  out_uart_tx_if.slave io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [7:0] out_q;
  logic tx_q, tx_n, overflow_q, full, push, pop, bit_end;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign push = io.load && !full;
  assign pop = state == IDLE && count != '0;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign io.tx = tx_q;
  assign io.busy = state != IDLE || count != '0;
  assign io.full = full;
  assign io.overflow = overflow_q;
  assign io.out = out_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx_q <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      tx_q <= tx_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = bit_end ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pop) begin
          state_n = START;
          shift_n = mem[rp];
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_idx_n = bit_idx + 1'b1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      default: if (bit_end) state_n = IDLE;
    endcase
  end
  // tx is registered from the next state so the line moves on the same edge as the FSM
  always_comb tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
        out_q <= io.bus;
      end
      if (pop) rp <= rp + 1'b1;
      if (io.load && full) overflow_q <= 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= io.bus;
endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: random and directed stimulus against a slot-based frame model of the output UART
module tb_out_uart_tx;
  localparam int CPB = 4;
  localparam int D = 4;
  localparam int FL = 10 * CPB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  out_uart_tx_if io();
  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  logic [7:0] out_m = 8'h00;
  bit ovf_m = 1'b0;
  bit act = 1'b0;
  int n = 0;
  int fs = 0;
  int sz;
  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  // model: each frame is ten CPB-long slots counted from its pop edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      act = 1'b0;
      n = 0;
      out_m = 8'h00;
      ovf_m = 1'b0;
    end else begin
      n++;
      sz = q.size();
      if ((!act || n > fs + FL) && sz != 0) begin
        fs = n;
        cur = q.pop_front();
        act = 1'b1;
      end
      if (io.load) begin
        if (sz < D) begin
          q.push_back(io.bus);
          out_m = io.bus;
        end else ovf_m = 1'b1;
      end
    end
  end
  initial forever begin
    int o;
    bit fr;
    logic tx_m;
    @(negedge clk);
    o = n - fs;
    fr = act && o < FL;
    tx_m = !fr ? 1'b1 : o / CPB == 0 ? 1'b0 : o / CPB == 9 ? 1'b1 : cur[o / CPB - 1];
    chk("model_tx", {7'd0, io.tx}, {7'd0, tx_m});
    chk("model_busy", {7'd0, io.busy}, {7'd0, fr || q.size() != 0});
    chk("model_full", {7'd0, io.full}, {7'd0, q.size() == D});
    chk("model_overflow", {7'd0, io.overflow}, {7'd0, ovf_m});
    chk("model_out", io.out, out_m);
  end
  initial begin
    logic [7:0] pat;
    int thr;
    io.load = 1'b0;
    io.bus = 8'h00;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      io.load = i[0];
      io.bus = 8'hFF;
      tick(1);
      chk("rst_tx", {7'd0, io.tx}, 8'd1);
      chk("rst_busy", {7'd0, io.busy}, 8'd0);
      chk("rst_full", {7'd0, io.full}, 8'd0);
      chk("rst_overflow", {7'd0, io.overflow}, 8'd0);
      chk("rst_out", io.out, 8'h00);
    end
    io.load = 1'b0;
    rst_n = 1'b1;
    tick(2);
    io.load = 1'b1;
    io.bus = 8'hA5;
    tick(1);
    io.load = 1'b0;
    chk("single_out", io.out, 8'hA5);
    chk("single_idle_tx", {7'd0, io.tx}, 8'd1);
    tick(1);
    chk("single_start", {7'd0, io.tx}, 8'd0);
    tick(4);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("single_bit", {7'd0, io.tx}, {7'd0, pat[i]});
      tick(4);
    end
    chk("single_stop", {7'd0, io.tx}, 8'd1);
    tick(3);
    chk("single_busy_end", {7'd0, io.busy}, 8'd1);
    tick(1);
    chk("single_busy_fall", {7'd0, io.busy}, 8'd0);
    tick(3);
    io.load = 1'b1;
    io.bus = 8'h01;
    tick(1);
    io.bus = 8'h80;
    tick(1);
    io.bus = 8'h3C;
    tick(1);
    io.load = 1'b0;
    tick(39);
    chk("b2b_gap", {7'd0, io.tx}, 8'd1);
    tick(1);
    chk("b2b_start2", {7'd0, io.tx}, 8'd0);
    tick(4);
    chk("b2b_bit0", {7'd0, io.tx}, 8'd0);
    tick(28);
    chk("b2b_bit7", {7'd0, io.tx}, 8'd1);
    tick(100);
    chk("b2b_overflow", {7'd0, io.overflow}, 8'd0);
    chk("b2b_busy", {7'd0, io.busy}, 8'd0);
    io.load = 1'b1;
    io.bus = 8'hEE;
    tick(1);
    io.load = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      io.load = 1'b1;
      io.bus = 8'h10 + 8'(i);
      tick(1);
      if (i == 3) begin
        chk("ovf_full", {7'd0, io.full}, 8'd1);
        chk("ovf_not_yet", {7'd0, io.overflow}, 8'd0);
      end
    end
    io.load = 1'b0;
    chk("ovf_set", {7'd0, io.overflow}, 8'd1);
    chk("ovf_out", io.out, 8'h13);
    tick(35);
    chk("ovf_next_start", {7'd0, io.tx}, 8'd0);
    tick(5 * 41 + 10);
    chk("ovf_sticky", {7'd0, io.overflow}, 8'd1);
    chk("ovf_drained", {7'd0, io.busy}, 8'd0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(1);
    io.load = 1'b1;
    io.bus = 8'hEE;
    tick(1);
    io.load = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      io.load = 1'b1;
      io.bus = 8'h20 + 8'(i);
      tick(1);
    end
    io.load = 1'b0;
    chk("pf_full", {7'd0, io.full}, 8'd1);
    tick(36);
    chk("pf_full_idle", {7'd0, io.full}, 8'd1);
    io.load = 1'b1;
    io.bus = 8'h77;
    tick(1);
    io.load = 1'b0;
    chk("pf_after_pop", {7'd0, io.full}, 8'd0);
    chk("pf_overflow", {7'd0, io.overflow}, 8'd1);
    chk("pf_out", io.out, 8'h23);
    io.load = 1'b1;
    io.bus = 8'h78;
    tick(1);
    io.load = 1'b0;
    chk("pf_refill", {7'd0, io.full}, 8'd1);
    chk("pf_refill_out", io.out, 8'h78);
    tick(5 * 41 + 10);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(1);
    io.load = 1'b1;
    io.bus = 8'h55;
    tick(1);
    io.bus = 8'hAA;
    tick(1);
    io.load = 1'b0;
    tick(17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {7'd0, io.tx}, 8'd1);
    chk("mid_rst_busy", {7'd0, io.busy}, 8'd0);
    chk("mid_rst_out", io.out, 8'h00);
    tick(1);
    #2;
    rst_n = 1'b1;
    tick(100);
    chk("mid_rst_quiet_tx", {7'd0, io.tx}, 8'd1);
    chk("mid_rst_quiet_busy", {7'd0, io.busy}, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      thr = i < 1000 ? 3 : i < 2000 ? 40 : 8;
      io.load = $urandom_range(0, 99) < thr;
      io.bus = 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick(1);
    end
    io.load = 1'b0;
    tick((D + 1) * 41 + 10);
    chk("rand_drained", {7'd0, io.busy}, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Output port for the 8-bit computer. It captures a byte from the shared bus when the controller asserts its load strobe, which is the same one-cycle load style used by the A, B and IR registers. Captured bytes are queued in a small FIFO and sent serially as 8N1 UART frames on `tx`. It is the reading end of the bus: the other modules drive bytes onto the bus, and this block consumes them and carries them off-chip. It also holds the last captured byte on `out` for LEDs.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per serial bit (≥2).
- FIFO_DEPTH, default 4: FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock (the halt-gated clock from the clock module); all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- load  in  1  capture strobe from the controller; sampled on rising clk.
- bus  in  8  shared data bus.
- tx  out  1  serial line, idle high.
- busy  out  1  high while FIFO non-empty or a frame is in progress.
- full  out  1  FIFO count == FIFO_DEPTH.
- overflow  out  1  sticky; set when a load is dropped; cleared only by rst.
- out  out  8  last accepted byte.

## Operation
- **Reset values** (rst low): tx=1, busy=0, full=0, overflow=0, out=8'h00, FIFO count=0, pointers=0, FSM=IDLE, baud counter=0, bit index=0.
- **Load**
  - Rising edge with load=1 and full=0: push bus into the FIFO and update out=bus.
  - Load with full=1: byte dropped, overflow←1, out unchanged.
  - `full` is the registered count. A load on the same edge as a pop while full is still dropped.
- **FIFO**
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - Count is 0..FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - There is no bypass: every byte passes through the FIFO.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count≠0, pop the head into a shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Baud counter** counts 0..CLKS_PER_BIT-1. The bit period ends on the edge where the counter equals CLKS_PER_BIT-1, and the counter wraps to 0.
- **tx is registered**: it changes only on clk edges. No glitches.
- **busy** = (FSM≠IDLE) | (count≠0).
- **Reset mid-frame**: the frame is aborted, tx returns high at once, and FIFO contents are discarded.

## Timing
- A load accepted at edge k gives count=1 and out valid after edge k.
- If the FSM is IDLE, the pop happens at edge k+1 and tx falls after edge k+1.
- A frame lasts exactly 10·CLKS_PER_BIT cycles: start + 8 data + stop.
- IDLE lasts 1 cycle between queued frames. Frame-start to frame-start is 10·CLKS_PER_BIT+1 cycles.
- For a single byte loaded at edge k, busy falls after edge k+1+10·CLKS_PER_BIT.
- Loads are accepted every cycle while count<FIFO_DEPTH, independent of the FSM.
- The head byte is popped in IDLE, so a depth-D FIFO plus the shift register holds D+1 bytes in flight.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Reset:** hold rst low, toggle load with bus=8'hFF → tx=1, busy=0, full=0, overflow=0, out=8'h00 throughout. Assert rst asynchronously between edges → outputs clear before the next edge.
- **Single byte:** load 8'hA5 at edge 0.
  - out=8'hA5 after edge 0.
  - tx is low for edges 1–5.
  - Data bits 1,0,1,0,0,1,0,1 follow, each 4 cycles.
  - Stop is high for edges 37–41.
  - busy falls after edge 41.
- **Back-to-back:** load 8'h01, 8'h80, 8'h3C on consecutive cycles → three correct frames, each 40 cycles long, starting 41 cycles apart. overflow=0.
- **Overflow:** with a frame in progress, load 8'h10–8'h15 on six consecutive cycles.
  - The first four are accepted and full=1.
  - The 5th and 6th are dropped: overflow=1 and out=8'h13.
  - Frames transmitted after the in-progress one are 8'h10–8'h13.
- **Load with pop while full:** with full=1, pulse load on the IDLE pop edge → byte dropped, overflow=1, count stays at FIFO_DEPTH-1 after the edge.
- **Reset mid-frame:** load 8'h55 and 8'hAA, then pull rst low during DATA bit 3.
  - tx=1 immediately.
  - After release: busy=0 and no further frames are sent.
